// File: rtl/interrupt_scheduler_pkg.sv
// interrupt_scheduler_pkg
//   Shared definitions for the interrupt scheduler and related controllers:
//   FSM state encodings, well-known source indices and the NOP instruction.
package interrupt_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } sched_state_t;

  // Well-known requester slots (lower index = higher priority).
  localparam int SRC_JUMP  = 0;
  localparam int SRC_FRAME = 1;

  // Value driven on the instruction bus when nothing is being injected.
  localparam logic [31:0] NOP_INSTR = 32'b0;

endpackage

// File: rtl/interrupt_scheduler_arbiter.sv
// fixed_priority_arbiter
//   Purely combinational fixed-priority pick: the lowest-index asserted
//   request wins.
// Ports:
//   req          in   N      request vector
//   grant_onehot out  N      one-hot grant (all zero when no request)
//   grant_idx    out  ID_W   index of the granted request (0 when none)
//   any_grant    out  1      at least one request is asserted
module fixed_priority_arbiter #(
  parameter int N = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant_onehot,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_grant
);

  // Scan from the highest index down so the last hit (lowest index) wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_onehot    = '0;
        grant_onehot[i] = 1'b1;
        grant_idx       = ID_W'(i);
        any_grant       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_scheduler.sv
// interrupt_scheduler
//   Shares the single CPU interrupt-instruction port between NUM_SRC event
//   sources. Rising edges on src_req are latched as pending; in IDLE the
//   lowest-index enabled pending source is granted and its instruction is
//   snapshotted and presented until acknowledged or timed out, then a
//   GAP_CYCLES quiet period is enforced before the next grant.
//
//   Handshake: while irq_valid=1 the instruction and grant_id are held
//   stable; a transfer completes on the cycle irq_valid && irq_ack are both
//   high at the clock edge. If no ack arrives within ACK_TIMEOUT cycles the
//   injection is abandoned (source stays pending). irq_ack is ignored when
//   irq_valid=0. All outputs come straight from registers.
//
// Ports:
//   proc_clk              in   1                 processor clock
//   reset                 in   1                 async active-low reset
//   src_req               in   NUM_SRC           request levels (0->1 = event)
//   src_instr             in   NUM_SRC*INSTR_W   flattened instruction buses
//   src_enable            in   NUM_SRC           per-source mask
//   irq_ack               in   1                 CPU consumed the instruction
//   interrupt_instruction out  INSTR_W           presented instruction / 0
//   irq_valid             out  1                 instruction valid
//   grant_id              out  ID_W              presented source (0 idle)
//   overrun               out  NUM_SRC           sticky merged-event flags
//   timeout_err           out  1                 sticky abandon flag
//   state_dbg             out  2                 current FSM state
module interrupt_scheduler
  import interrupt_scheduler_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int INSTR_W     = 32,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 64,
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         proc_clk,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           src_req,
  input  logic [NUM_SRC*INSTR_W-1:0]   src_instr,
  input  logic [NUM_SRC-1:0]           src_enable,
  input  logic                         irq_ack,
  output logic [INSTR_W-1:0]           interrupt_instruction,
  output logic                         irq_valid,
  output logic [ID_W-1:0]              grant_id,
  output logic [NUM_SRC-1:0]           overrun,
  output logic                         timeout_err,
  output sched_state_t                 state_dbg
);

  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  sched_state_t         state_q, state_next;
  logic [NUM_SRC-1:0]   req_q;
  logic [NUM_SRC-1:0]   pending_q;
  logic [NUM_SRC-1:0]   overrun_q;
  logic                 timeout_q;
  logic [15:0]          tmo_cnt_q;
  logic [7:0]           gap_cnt_q;
  logic [ID_W-1:0]      grant_q;
  logic [INSTR_W-1:0]   instr_q;

  logic [NUM_SRC-1:0]   edge_det;
  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   clr;
  logic [NUM_SRC-1:0]   arb_onehot;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;
  logic [INSTR_W-1:0]   arb_instr;
  logic                 load;
  logic                 ack_take;
  logic                 tmo_fire;

  // Masked sources neither register new edges nor compete, but keep any
  // event already pending.
  assign edge_det = src_req & ~req_q & src_enable;
  assign eligible = pending_q & src_enable;

  fixed_priority_arbiter #(.N(NUM_SRC)) u_arb (
    .req          (eligible),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any_grant    (arb_any)
  );

  // Instruction of the winning source, captured on the IDLE->PRESENT step.
  always_comb begin
    arb_instr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_onehot[i]) arb_instr = src_instr[i*INSTR_W +: INSTR_W];
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    load       = 1'b0;
    ack_take   = 1'b0;
    tmo_fire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_next = ST_PRESENT;
          load       = 1'b1;
        end
      end
      ST_PRESENT: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (irq_ack) begin
          ack_take   = 1'b1;
          state_next = ST_GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_fire   = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Only an acknowledged grant clears its pending bit.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = ack_take && (grant_q == ID_W'(i));
    end
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      req_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      req_q     <= src_req;
      // A new edge beats a same-cycle clear, so the event is not lost.
      pending_q <= (pending_q & ~clr) | edge_det;
      overrun_q <= overrun_q | (edge_det & pending_q & ~clr);
      if (tmo_fire) timeout_q <= 1'b1;
    end
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (state_q == ST_PRESENT && state_next == ST_PRESENT) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end else begin
        tmo_cnt_q <= '0;
      end
      if (state_q == ST_GAP && state_next == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q + 8'd1;
      end else begin
        gap_cnt_q <= '0;
      end
    end
  end

  // Presented grant/instruction: loaded on grant, held through PRESENT,
  // zeroed when the injection ends so idle outputs read as NOP / source 0.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      instr_q <= '0;
    end else if (load) begin
      grant_q <= arb_idx;
      instr_q <= arb_instr;
    end else if (state_q == ST_PRESENT && state_next != ST_PRESENT) begin
      grant_q <= '0;
      instr_q <= '0;
    end
  end

  assign irq_valid             = (state_q == ST_PRESENT);
  assign interrupt_instruction = instr_q;
  assign grant_id              = grant_q;
  assign overrun               = overrun_q;
  assign timeout_err           = timeout_q;
  assign state_dbg             = state_q;

endmodule
